// File: rtl/fft_helpers_bit_reverse_ctrl.sv
// fft_helpers_bit_reverse_ctrl
//
// Streaming bit-reversal reorder controller for the FFT input path. Samples
// arrive one per handshake in natural order. Once a full frame of N_SAMPLES
// has been buffered, the frame is emitted in bit-reversed index order.
//
// Build option:
//   FFT_BITREV_PINGPONG_EN  When defined, the design uses two banks with full
//                           flags, so one frame can fill while the previous one
//                           drains (1 sample/cycle sustained). When undefined,
//                           there is a single bank and a FILL/DRAIN FSM.
//
// Parameters:
//   BIT_WIDTH  sample width in bits
//   N_SAMPLES  frame length (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears counters, flags and buffers
//   recv_msg   input sample, natural order
//   recv_val   recv_msg valid
//   recv_rdy   controller can accept a sample (registered state only)
//   send_msg   output sample, bit-reversed order (combinational buffer read)
//   send_val   send_msg valid (registered state only)
//   send_rdy   downstream accepts
//   send_last  high with the final sample of an output frame

module fft_helpers_bit_reverse_ctrl #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic                 send_last
);

  localparam int unsigned IdxW = $clog2(N_SAMPLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_SAMPLES - 1);

  // Mirror the index bits: bit i moves to bit IdxW-1-i.
  function automatic logic [IdxW-1:0] rev_idx(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] r;
    for (int i = 0; i < IdxW; i++) begin
      r[i] = idx[IdxW-1-i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Write / read counters (shared by both build variants)
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0] rd_cnt_q, rd_cnt_d;
  logic            wr_fire;
  logic            rd_fire;
  logic            wr_last;
  logic            rd_last;

  assign wr_fire = recv_val & recv_rdy;
  assign rd_fire = send_val & send_rdy;
  assign wr_last = (wr_cnt_q == LastIdx);
  assign rd_last = (rd_cnt_q == LastIdx);

  // N_SAMPLES is a power of two, so the natural wrap of IdxW bits is the
  // frame-boundary wrap.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + IdxW'(1);
    end
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign send_last = send_val & rd_last;

`ifdef FFT_BITREV_PINGPONG_EN
  // ---------------------------------------------------------------------------
  // Two-bank ping-pong buffer
  // ---------------------------------------------------------------------------
  logic [BIT_WIDTH-1:0] mem_q [2][N_SAMPLES];
  logic [BIT_WIDTH-1:0] mem_d [2][N_SAMPLES];
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;

  assign recv_rdy = ~full_q[wr_bank_q];
  assign send_val = full_q[rd_bank_q];
  assign send_msg = mem_q[rd_bank_q][rev_idx(rd_cnt_q)];

  // A write completion and a read completion on the same edge always target
  // different banks (the write bank is empty, the read bank is full), so the
  // two flag updates never collide.
  always_comb begin
    mem_d     = mem_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      mem_d[wr_bank_q][wr_cnt_q] = recv_msg;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_fire && rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Single bank with FILL / DRAIN FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    StFill,
    StDrain
  } state_e;

  state_e               state_q, state_d;
  logic                 recv_rdy_q, recv_rdy_d;
  logic                 send_val_q, send_val_d;
  logic [BIT_WIDTH-1:0] mem_q [N_SAMPLES];
  logic [BIT_WIDTH-1:0] mem_d [N_SAMPLES];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (wr_fire && wr_last) state_d = StDrain;
      StDrain: if (rd_fire && rd_last) state_d = StFill;
      default: state_d = StFill;
    endcase
    // Handshake outputs are registered copies of the next state, so they
    // never depend combinationally on recv_val or send_rdy.
    recv_rdy_d = (state_d == StFill);
    send_val_d = (state_d == StDrain);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFill;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      recv_rdy_q <= recv_rdy_d;
      send_val_q <= send_val_d;
    end
  end

  assign recv_rdy = recv_rdy_q;
  assign send_val = send_val_q;
  assign send_msg = mem_q[rev_idx(rd_cnt_q)];

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[wr_cnt_q] = recv_msg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end
`endif

endmodule
